alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, handshaked successor to the combinational datapath ALU, parametrised in WIDTH.
- Adds carry flag, valid/ready flow control on input and output, and iterative multi-cycle shift ops on opcodes 6/7 (selectable by EXT_OPS).
- Sits between the decoder/operand fetch and the accumulator write-back in the CPU datapath.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 2
EXT_OPS, 1, 1: opcode 6 = SHL, opcode 7 = SHR (iterative); 0: opcodes 6/7 pass in_a (legacy behaviour)
CW, $clog2(WIDTH), derived shift-count width; not to be overridden

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept; transfer when in_valid && in_ready
opcode  input  3  0 PASS0, 1 PASS1, 2 ADD, 3 AND, 4 XOR, 5 PASSB, 6 PASS6/SHL, 7 PASS7/SHR
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B; shift amount = in_b[CW-1:0]
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  consumer accepts result; transfer when out_valid && out_ready
alu_out  output  WIDTH  registered result
a_is_zero  output  1  registered (in_a == 0) of the accepted operation
carry_out  output  1  ADD carry / last bit shifted out; 0 for other ops
busy  output  1  high while in SHIFT state

Behaviour:
- Reset (rst=1 at edge): state=IDLE; alu_out, a_is_zero, carry_out, out_valid, busy = 0; shift counter = 0. in_ready is forced 0 while rst=1. Reset mid-shift aborts the operation; no result is produced.
- States: IDLE, SHIFT.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready). A new op may be accepted in the same cycle a result is consumed.
- Result functions: PASS0/PASS1 -> in_a; ADD -> (in_a+in_b) mod 2^WIDTH, carry_out = bit WIDTH of the sum; AND -> in_a&in_b; XOR -> in_a^in_b; PASSB -> in_b. With EXT_OPS=0, opcodes 6/7 -> in_a. carry_out=0 for all ops except ADD/SHL/SHR.
- a_is_zero is captured from in_a at accept and held with its result, for every opcode.
- Single-cycle ops, and shifts with amount n=0: on the accept edge, the result and flags are registered and out_valid=1. Latency is 1 cycle; carry_out=0 for n=0, alu_out=in_a.
- Logical shifts (zero fill), n>=1:
  - Accept edge: working reg = in_a shifted 1 bit; carry = bit shifted out; counter = n-1.
  - If counter==0, out_valid=1; else state=SHIFT, busy=1.
  - In SHIFT, each edge shifts 1 bit, updates carry, and decrements the counter.
  - On the edge where counter reaches 0: state=IDLE, busy=0, out_valid=1.
  - Result latency = n cycles after accept.
- alu_out/carry_out may change internally during SHIFT. Consumers sample them only when out_valid=1.
- Output hold: while out_valid && !out_ready, alu_out, a_is_zero and carry_out are stable, and no new op is accepted.
- On a transfer edge (out_valid && out_ready): out_valid clears unless a new single-cycle/n<=1 op is accepted on the same edge, in which case out_valid stays 1 with the new result.
- in_valid while !in_ready: inputs are ignored; the producer holds them.
- No combinational path from in_* to out_*; in_ready depends only on state, out_valid, out_ready and rst.

Test Plan:
- Reset then ADD in_a=8'h42 in_b=8'h86 -> next cycle out_valid=1, alu_out=8'hC8, carry_out=0, a_is_zero=0. Then ADD 8'hFF+8'h01 -> alu_out=8'h00, carry_out=1, a_is_zero=0.
- Legacy sweep, out_ready=1, in_a=8'h42 in_b=8'h86, opcodes 0..5 back-to-back -> one result per cycle: 42,42,C8,02,C4,86. With EXT_OPS=0, opcodes 6/7 -> 42. PASS7 with in_a=8'h00 -> alu_out=00, a_is_zero=1.
- EXT_OPS=1 shifts:
  - SHL in_a=8'h42 in_b=3 -> busy for 2 cycles, in_ready=0, out_valid 3 cycles after accept, alu_out=8'h10, carry_out=0.
  - SHR in_a=8'h86 in_b=2 -> alu_out=8'h21, carry_out=1, latency 2.
  - SHL with in_b=0 -> alu_out=8'h42, carry_out=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after XOR 42^86 -> out_valid and alu_out=8'hC4 stable, in_ready=0. Raise out_ready while in_valid=1 with a new AND -> same-edge consume and accept, next result 8'h02.
- Reset mid-SHL (in_b=7, rst asserted 2 cycles after accept) -> next cycle out_valid=0, busy=0, alu_out=0, carry_out=0. After rst drops, in_ready=1 and a fresh ADD completes normally.
- WIDTH=16, EXT_OPS=1: ADD 16'hFFFF+16'h0002 -> 16'h0001, carry_out=1. SHR 16'h8000 by 15 -> 16'h0001, latency 15 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with carry flag and iterative one-bit-per-cycle
// logical shifts on opcodes 6/7 when EXT_OPS is set.
module alu_seq #(
   parameter int WIDTH   = 8,
   parameter bit EXT_OPS = 1'b1,
   parameter int CW      = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             a_is_zero,
   output logic             carry_out,
   output logic             busy
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             aZero_q, aZero_d;
   logic             outValid_q, outValid_d;
   logic             shiftLeft_q, shiftLeft_d;
   logic [CW-1:0]    shiftCnt_q, shiftCnt_d;

   logic             accept;
   logic             isShift;
   logic [CW-1:0]    shAmt;
   logic [WIDTH:0]   sum;

   assign in_ready  = !rst && (state_q == IDLE) && (!outValid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign shAmt     = in_b[CW-1:0];
   assign isShift   = EXT_OPS && (opcode[2:1] == 2'b11);
   assign sum       = {1'b0, in_a} + {1'b0, in_b};

   assign alu_out   = result_q;
   assign a_is_zero = aZero_q;
   assign carry_out = carry_q;
   assign out_valid = outValid_q;
   assign busy      = (state_q == SHIFT);

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      carry_d     = carry_q;
      aZero_d     = aZero_q;
      outValid_d  = outValid_q;
      shiftLeft_d = shiftLeft_q;
      shiftCnt_d  = shiftCnt_q;

      if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               aZero_d    = (in_a == '0);
               carry_d    = 1'b0;
               outValid_d = 1'b1;
               case (opcode)
                  3'd2: begin
                     result_d = sum[WIDTH-1:0];
                     carry_d  = sum[WIDTH];
                  end
                  3'd3:    result_d = in_a & in_b;
                  3'd4:    result_d = in_a ^ in_b;
                  3'd5:    result_d = in_b;
                  default: result_d = in_a;
               endcase
               // First shift step happens on the accept edge; a count of one finishes here
               if (isShift && (shAmt != '0)) begin
                  shiftLeft_d = !opcode[0];
                  result_d    = opcode[0] ? {1'b0, in_a[WIDTH-1:1]} : {in_a[WIDTH-2:0], 1'b0};
                  carry_d     = opcode[0] ? in_a[0] : in_a[WIDTH-1];
                  shiftCnt_d  = shAmt - CW'(1);
                  if (shAmt != CW'(1)) begin
                     outValid_d = 1'b0;
                     state_d    = SHIFT;
                  end
               end
            end
         end
         SHIFT: begin
            result_d   = shiftLeft_q ? {result_q[WIDTH-2:0], 1'b0} : {1'b0, result_q[WIDTH-1:1]};
            carry_d    = shiftLeft_q ? result_q[WIDTH-1] : result_q[0];
            shiftCnt_d = shiftCnt_q - CW'(1);
            if (shiftCnt_q == CW'(1)) begin
               state_d    = IDLE;
               outValid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         result_q    <= '0;
         carry_q     <= 1'b0;
         aZero_q     <= 1'b0;
         outValid_q  <= 1'b0;
         shiftLeft_q <= 1'b0;
         shiftCnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         aZero_q     <= aZero_d;
         outValid_q  <= outValid_d;
         shiftLeft_q <= shiftLeft_d;
         shiftCnt_q  <= shiftCnt_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: three instances (8-bit with shifts, 8-bit legacy,
// 16-bit with shifts) share operands and out_ready but have separate in_valid.
module tb_alu_seq;

   typedef struct {
      logic [15:0] res;
      logic        carry;
      logic        zero;
      int          lat;
      int          acc;
      string       name;
   } expT;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  opcode;
   logic [15:0] inA, inB;
   logic        iv0, iv1, iv2;
   logic        outReady;

   logic        rdy0, ov0, z0, c0, busy0;
   logic [7:0]  out0;
   logic        rdy1, ov1, z1, c1, busy1;
   logic [7:0]  out1;
   logic        rdy2, ov2, z2, c2, busy2;
   logic [15:0] out2;

   logic [15:0] res[3];
   logic        ovA[3], cA[3], zA[3], rdyA[3];

   expT q0[$], q1[$], q2[$];
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;

   // Clock and cycle counter used for latency measurement
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_seq #(.WIDTH(8), .EXT_OPS(1'b1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .opcode(opcode),
      .in_a(inA[7:0]), .in_b(inB[7:0]), .out_valid(ov0), .out_ready(outReady),
      .alu_out(out0), .a_is_zero(z0), .carry_out(c0), .busy(busy0));

   alu_seq #(.WIDTH(8), .EXT_OPS(1'b0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .opcode(opcode),
      .in_a(inA[7:0]), .in_b(inB[7:0]), .out_valid(ov1), .out_ready(outReady),
      .alu_out(out1), .a_is_zero(z1), .carry_out(c1), .busy(busy1));

   alu_seq #(.WIDTH(16), .EXT_OPS(1'b1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .opcode(opcode),
      .in_a(inA), .in_b(inB), .out_valid(ov2), .out_ready(outReady),
      .alu_out(out2), .a_is_zero(z2), .carry_out(c2), .busy(busy2));

   assign res[0] = {8'h00, out0};
   assign res[1] = {8'h00, out1};
   assign res[2] = out2;
   assign ovA[0] = ov0;
   assign ovA[1] = ov1;
   assign ovA[2] = ov2;
   assign cA[0]  = c0;
   assign cA[1]  = c1;
   assign cA[2]  = c2;
   assign zA[0]  = z0;
   assign zA[1]  = z1;
   assign zA[2]  = z2;
   assign rdyA[0] = rdy0;
   assign rdyA[1] = rdy1;
   assign rdyA[2] = rdy2;

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic pushExp(input int sel, input expT e);
      case (sel)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic popExp(input int sel, output expT e, output bit ok);
      ok = 1'b0;
      case (sel)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   function automatic bit allEmpty();
      return (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
   endfunction

   // Drives one operation into the selected instance; entered and left at posedge+1
   task automatic applyStimulus(input int sel, input logic [2:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] expRes,
                                input logic expCarry, input logic expZero,
                                input int lat, input bit push, input string nm);
      expT e;
      bit  got;
      opcode = op;
      inA    = a;
      inB    = b;
      iv0    = (sel == 0);
      iv1    = (sel == 1);
      iv2    = (sel == 2);
      got    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rdyA[sel]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL %s.acceptTimeout: got no in_ready expected in_ready within 100 cycles", nm);
      end else if (push) begin
         e.res   = expRes;
         e.carry = expCarry;
         e.zero  = expZero;
         e.lat   = lat;
         e.acc   = cyc + 1;
         e.name  = nm;
         pushExp(sel, e);
      end
      @(posedge clk);
      #1;
      iv0 = 1'b0;
      iv1 = 1'b0;
      iv2 = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (allEmpty()) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("[TB] FAIL drainTimeout: got %0d/%0d/%0d pending expected 0/0/0",
                  q0.size(), q1.size(), q2.size());
      end
   endtask

   // Monitor: pops and compares on every negedge where a result is being transferred
   initial begin : monitor
      bit  pv[3];
      bit  pt[3];
      int  startCyc[3];
      expT e;
      bit  ok;
      for (int k = 0; k < 3; k++) begin
         pv[k] = 1'b0;
         pt[k] = 1'b0;
         startCyc[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rst) begin
               pv[k] = 1'b0;
               pt[k] = 1'b0;
            end else begin
               if (ovA[k] && (!pv[k] || pt[k])) startCyc[k] = cyc;
               if (ovA[k] && outReady) begin
                  popExp(k, e, ok);
                  if (!ok) begin
                     total++;
                     bad++;
                     $display("[TB] FAIL unexpectedResult dut%0d: got result %0h expected none", k, res[k]);
                  end else begin
                     checkOutput({e.name, ".alu_out"}, 32'(res[k]), 32'(e.res));
                     checkOutput({e.name, ".carry_out"}, 32'(cA[k]), 32'(e.carry));
                     checkOutput({e.name, ".a_is_zero"}, 32'(zA[k]), 32'(e.zero));
                     if (e.lat > 0) checkOutput({e.name, ".latency"}, startCyc[k] - e.acc + 1, e.lat);
                  end
               end
               pv[k] = ovA[k];
               pt[k] = ovA[k] && outReady;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int c;
      rst      = 1'b1;
      iv0      = 1'b0;
      iv1      = 1'b0;
      iv2      = 1'b0;
      outReady = 1'b1;
      opcode   = 3'd0;
      inA      = 16'h0;
      inB      = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst.out_valid", 32'(ov0), 0);
      checkOutput("rst.alu_out", 32'(out0), 0);
      checkOutput("rst.carry_out", 32'(c0), 0);
      checkOutput("rst.a_is_zero", 32'(z0), 0);
      checkOutput("rst.busy", 32'(busy0), 0);
      checkOutput("rst.in_ready", 32'(rdy0), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postRst.in_ready", 32'(rdy0), 1);
      @(posedge clk);
      #1;

      applyStimulus(0, 3'd2, 16'h42, 16'h86, 16'hC8, 1'b0, 1'b0, 1, 1'b1, "add42_86");
      applyStimulus(0, 3'd2, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b0, 1, 1'b1, "addFF_01");
      waitDrain(50);

      // Legacy sweep: one accept per cycle while the consumer is always ready
      c = cyc;
      applyStimulus(1, 3'd0, 16'h42, 16'h86, 16'h42, 1'b0, 1'b0, 1, 1'b1, "legPass0");
      applyStimulus(1, 3'd1, 16'h42, 16'h86, 16'h42, 1'b0, 1'b0, 1, 1'b1, "legPass1");
      applyStimulus(1, 3'd2, 16'h42, 16'h86, 16'hC8, 1'b0, 1'b0, 1, 1'b1, "legAdd");
      applyStimulus(1, 3'd3, 16'h42, 16'h86, 16'h02, 1'b0, 1'b0, 1, 1'b1, "legAnd");
      applyStimulus(1, 3'd4, 16'h42, 16'h86, 16'hC4, 1'b0, 1'b0, 1, 1'b1, "legXor");
      applyStimulus(1, 3'd5, 16'h42, 16'h86, 16'h86, 1'b0, 1'b0, 1, 1'b1, "legPassB");
      applyStimulus(1, 3'd6, 16'h42, 16'h03, 16'h42, 1'b0, 1'b0, 1, 1'b1, "legPass6");
      applyStimulus(1, 3'd7, 16'h42, 16'h03, 16'h42, 1'b0, 1'b0, 1, 1'b1, "legPass7");
      applyStimulus(1, 3'd7, 16'h00, 16'h03, 16'h00, 1'b0, 1'b1, 1, 1'b1, "legPass7Zero");
      checkOutput("legSweepCycles", cyc - c, 9);
      waitDrain(50);

      applyStimulus(0, 3'd6, 16'h42, 16'h03, 16'h10, 1'b0, 1'b0, 3, 1'b1, "shl42_3");
      @(negedge clk);
      checkOutput("shl.busy1", 32'(busy0), 1);
      checkOutput("shl.in_ready1", 32'(rdy0), 0);
      @(negedge clk);
      checkOutput("shl.busy2", 32'(busy0), 1);
      checkOutput("shl.in_ready2", 32'(rdy0), 0);
      @(negedge clk);
      checkOutput("shl.busyDone", 32'(busy0), 0);
      waitDrain(50);
      applyStimulus(0, 3'd7, 16'h86, 16'h02, 16'h21, 1'b1, 1'b0, 2, 1'b1, "shr86_2");
      applyStimulus(0, 3'd6, 16'h42, 16'h00, 16'h42, 1'b0, 1'b0, 1, 1'b1, "shl42_0");
      waitDrain(50);

      // Backpressure: result must hold while the consumer stalls
      outReady = 1'b0;
      applyStimulus(0, 3'd4, 16'h42, 16'h86, 16'hC4, 1'b0, 1'b0, 1, 1'b1, "xorHeld");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold.out_valid", 32'(ov0), 1);
         checkOutput("hold.alu_out", 32'(out0), 32'h C4);
         checkOutput("hold.in_ready", 32'(rdy0), 0);
      end
      @(posedge clk);
      #1;
      outReady = 1'b1;
      applyStimulus(0, 3'd3, 16'h42, 16'h86, 16'h02, 1'b0, 1'b0, 1, 1'b1, "andSameEdge");
      waitDrain(50);

      // Reset during a long shift discards the operation
      applyStimulus(0, 3'd6, 16'h42, 16'h07, 16'h00, 1'b0, 1'b0, 0, 1'b0, "shlAborted");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRst.out_valid", 32'(ov0), 0);
      checkOutput("midRst.busy", 32'(busy0), 0);
      checkOutput("midRst.alu_out", 32'(out0), 0);
      checkOutput("midRst.carry_out", 32'(c0), 0);
      checkOutput("midRst.in_ready", 32'(rdy0), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("afterRst.in_ready", 32'(rdy0), 1);
      @(posedge clk);
      #1;
      applyStimulus(0, 3'd2, 16'h10, 16'h20, 16'h30, 1'b0, 1'b0, 1, 1'b1, "addAfterRst");
      applyStimulus(0, 3'd2, 16'h00, 16'h05, 16'h05, 1'b0, 1'b1, 1, 1'b1, "addZeroA");
      waitDrain(50);

      applyStimulus(2, 3'd2, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1, 1'b1, "w16AddCarry");
      applyStimulus(2, 3'd7, 16'h8000, 16'd15, 16'h0001, 1'b0, 1'b0, 15, 1'b1, "w16Shr15");
      waitDrain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
